// File: rtl/bcd_key_entry.sv
// rtl/bcd_key_entry.sv - debounced two-digit BCD key entry register with BCD countdown
// Define KEY_DEBOUNCE_EN to enable the DEB_CYCLES press/release debounce; otherwise keys are accepted on first sight.
module bcd_key_entry #(
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd_in,
  input  logic       clr,
  input  logic       start,
  input  logic       tick,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_units,
  output logic       key_stb,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} key_state_t;

  key_state_t state_q, state_d;
  logic [3:0] sync1, s;
  logic       valid;
  logic       accept;

  assign valid = (s != 4'd0) && (s <= 4'd9);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 4'd0;
      s     <= 4'd0;
    end else begin
      sync1 <= bcd_in;
      s     <= sync1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES);
  localparam bit               DEB_ONE  = (DEB_CYCLES == 1);

  logic [DEB_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       code_q, code_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  // cnt counts identical samples already seen; the transition fires on the DEB_CYCLES-th one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          code_d = s;
          if (DEB_ONE) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            state_d = PRESS;
            cnt_d   = DEB_W'(1);
          end
        end
      end
      PRESS: begin
        if (s == code_q) begin
          if (cnt_inc == DEB_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (s == 4'd0) begin
          if (DEB_ONE) begin
            state_d = IDLE;
          end else begin
            state_d = RELEASE;
            cnt_d   = DEB_W'(1);
          end
        end
      end
      RELEASE: begin
        if (s == 4'd0) begin
          if (cnt_inc == DEB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = HELD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    accept = 1'b0;
    case (state_q)
      IDLE:    accept = valid && DEB_ONE;
      PRESS:   accept = (s == code_q) && (cnt_inc == DEB_LAST);
      default: accept = 1'b0;
    endcase
  end
`else
  logic deb_cfg_unused;
  assign deb_cfg_unused = (DEB_CYCLES != DEB_W);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = HELD;
      HELD:    if (s == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == IDLE) && valid;
  end
`endif

  // An accepted digit is always the current synchronised code, so no separate latch is needed here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens      <= 4'd0;
      units     <= 4'd0;
      cnt_tens  <= 4'd0;
      cnt_units <= 4'd0;
      key_stb   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      key_stb <= 1'b0;
      done    <= 1'b0;
      if (clr) begin
        tens  <= 4'd0;
        units <= 4'd0;
      end else if (accept) begin
        tens    <= units;
        units   <= s;
        key_stb <= 1'b1;
      end
      if (!busy) begin
        if (start) begin
          cnt_tens  <= tens;
          cnt_units <= units;
          busy      <= ({tens, units} != 8'h00);
          done      <= ({tens, units} == 8'h00);
        end
      end else if (tick) begin
        if ({cnt_tens, cnt_units} == 8'h01) begin
          cnt_units <= 4'd0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end else if (cnt_units == 4'd0) begin
          cnt_units <= 4'd9;
          cnt_tens  <= cnt_tens - 4'd1;
        end else begin
          cnt_units <= cnt_units - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_key_entry.sv
// tb/tb_bcd_key_entry.sv - directed bench with behavioural model for bcd_key_entry
module tb_bcd_key_entry;
  localparam int DEB = 4;
`ifdef KEY_DEBOUNCE_EN
  localparam int D = DEB;
`else
  localparam int D = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n, clr, start, tick;
  logic [3:0] bcd_in;
  logic [3:0] tens, units, cnt_tens, cnt_units;
  logic       key_stb, busy, done;

  always #5 clk = ~clk;

  bcd_key_entry #(.DEB_CYCLES(DEB), .DEB_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .clr(clr), .start(start), .tick(tick),
    .tens(tens), .units(units), .cnt_tens(cnt_tens), .cnt_units(cnt_units),
    .key_stb(key_stb), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int stb_cnt, first_stb, edge_ctr, done_cnt;

  // Model: pipe of raw samples, debounce as run lengths, entry and countdown as plain integers 0..99
  int m_p0, m_p1, m_run, m_code, m_ent, m_cnt;
  bit m_hold, m_stb, m_busy, m_done;

  always @(posedge clk) begin
    int  sv;
    bit  acc;
    if (!rst_n) begin
      m_p0 = 0; m_p1 = 0; m_run = 0; m_code = 0; m_ent = 0; m_cnt = 0;
      m_hold = 0; m_stb = 0; m_busy = 0; m_done = 0;
    end else begin
      sv  = m_p1;
      acc = 0;
      if (!m_hold) begin
        if (m_run == 0) begin
          if (sv >= 1 && sv <= 9) begin m_code = sv; m_run = 1; end
        end else if (sv == m_code) m_run++;
        else m_run = 0;
        if (m_run >= D) begin acc = 1; m_hold = 1; m_run = 0; end
      end else begin
        if (sv == 0) m_run++;
        else m_run = 0;
        if (m_run >= D) begin m_hold = 0; m_run = 0; end
      end
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_cnt  = m_ent;
          m_busy = (m_ent != 0);
          m_done = (m_ent == 0);
        end
      end else if (tick) begin
        m_cnt--;
        if (m_cnt == 0) begin m_busy = 0; m_done = 1; end
      end
      m_stb = 0;
      if (clr) m_ent = 0;
      else if (acc) begin m_ent = (m_ent % 10) * 10 + sv; m_stb = 1; end
      m_p1 = m_p0;
      m_p0 = int'(bcd_in);
    end
  end

  always @(posedge clk) begin
    #1;
    checks++;
    if (int'(tens) != m_ent / 10 || int'(units) != m_ent % 10 ||
        int'(cnt_tens) != m_cnt / 10 || int'(cnt_units) != m_cnt % 10 ||
        key_stb != m_stb || busy != m_busy || done != m_done) begin
      errors++;
      $display("FAIL model_cycle t=%0t actual tens=%0d units=%0d cnt=%0d%0d stb=%0b busy=%0b done=%0b required tens=%0d units=%0d cnt=%0d busy=%0b stb=%0b done=%0b",
               $time, tens, units, cnt_tens, cnt_units, key_stb, busy, done,
               m_ent / 10, m_ent % 10, m_cnt, m_busy, m_stb, m_done);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic meas_clear();
    stb_cnt = 0; first_stb = -1; edge_ctr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_ctr++;
    if (key_stb) begin
      stb_cnt++;
      if (first_stb < 0) first_stb = edge_ctr;
    end
    if (done) done_cnt++;
  endtask

  task automatic seg(input int code, input int n);
    bcd_in = 4'(code);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; bcd_in = 4'd5; start = 1'b1; tick = 1'b1; clr = 1'b0;
    meas_clear();
    for (int i = 0; i < 3; i++) step();
    chk("reset_outputs", int'({tens, units, cnt_tens, cnt_units, key_stb, busy, done}), 0);
    chk("reset_no_stb", stb_cnt, 0);
    rst_n = 1'b1; start = 1'b0; tick = 1'b0;
    seg(0, 5);

    // keys 4 then 7
    meas_clear(); seg(4, 10);
    chk("key4_latency", first_stb, 2 + D);
    chk("key4_stb_count", stb_cnt, 1);
    seg(0, 10);
    meas_clear(); seg(7, 10);
    chk("key7_latency", first_stb, 2 + D);
    seg(0, 10);
    chk("key7_stb_count", stb_cnt, 1);
    chk("entry_47_tens", int'(tens), 4);
    chk("entry_47_units", int'(units), 7);

    // bounce on 3
    meas_clear();
    for (int i = 0; i < 3; i++) begin seg(3, 2); seg(0, 2); end
`ifdef KEY_DEBOUNCE_EN
    chk("bounce_no_stb", stb_cnt, 0);
`else
    chk("bounce_raw_stb", stb_cnt, 3);
`endif
    seg(3, 12); seg(0, 10);
    chk("bounce_total_stb", stb_cnt, (D == 1) ? 4 : 1);
    chk("bounce_units", int'(units), 3);

    // invalid code in IDLE, then during HELD
    meas_clear(); seg(10, 20);
    chk("invalid_idle_stb", stb_cnt, 0);
    chk("invalid_idle_tens", int'(tens), (D == 1) ? 3 : 7);
    meas_clear(); seg(6, 10); seg(10, 10); seg(6, 10); seg(0, 10);
    chk("invalid_held_stb", stb_cnt, 1);
    chk("invalid_held_units", int'(units), 6);

    // entry 12, countdown
    clr = 1'b1; step(); clr = 1'b0;
    seg(1, 10); seg(0, 10); seg(2, 10); seg(0, 10);
    chk("entry_12", int'({tens, units}), 8'h12);
    start = 1'b1; step(); start = 1'b0;
    chk("load_12_busy", int'(busy), 1);
    chk("load_12_cnt", int'({cnt_tens, cnt_units}), 8'h12);
    done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      int v;
      v = 12 - k;
      tick = 1'b1; step(); tick = 1'b0;
      chk("tick_cnt", int'({cnt_tens, cnt_units}), (v / 10) * 16 + v % 10);
      chk("tick_done", int'(done), (k == 12) ? 1 : 0);
      step(); step();
    end
    chk("countdown_busy_end", int'(busy), 0);
    for (int k = 0; k < 3; k++) begin tick = 1'b1; step(); tick = 1'b0; step(); end
    chk("extra_ticks_cnt", int'({cnt_tens, cnt_units}), 0);
    chk("countdown_done_pulses", done_cnt, 1);

    // clr coincident with accept: clr wins
    bcd_in = 4'd5; meas_clear();
    for (int i = 1; i <= 10; i++) begin
      clr = (i == 2 + D);
      step();
    end
    clr = 1'b0;
    seg(0, 10);
    chk("clr_accept_stb", stb_cnt, 0);
    chk("clr_accept_entry", int'({tens, units}), 0);

    // start with entry 00
    start = 1'b1; step(); start = 1'b0;
    chk("zero_start_done", int'(done), 1);
    chk("zero_start_busy", int'(busy), 0);
    step();
    chk("zero_done_once", int'(done), 0);

    // entry 03: start+tick together loads only; start while busy ignored
    seg(3, 10); seg(0, 10);
    start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
    chk("start_tick_load", int'({cnt_tens, cnt_units}), 8'h03);
    chk("start_tick_busy", int'(busy), 1);
    for (int k = 1; k <= 3; k++) begin
      tick = 1'b1; start = 1'b1; step(); tick = 1'b0; start = 1'b0;
      chk("busy_start_cnt", int'(cnt_units), 3 - k);
      step();
    end
    chk("short_countdown_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
